// File: rtl/and_term_tally_pkg.sv
// rtl/and_term_tally_pkg.sv - shared types and default sizing for the AND-term tally block
//
// Purpose : FSM state enum, default parameter values, window counter width
//           and the index-width helper used by the interface and the top.
// Ports   : none (package).

package and_term_tally_pkg;

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   localparam int DEF_NUM_TERMS = 11;
   localparam int DEF_CNT_W     = 8;
   localparam int DEF_WINDOW    = 16;

   // Window counter is sized for the largest legal WINDOW (65535).
   localparam int WIN_W = 16;

   // A single-term block still needs a 1-bit index port.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_IDX_W = idx_width(DEF_NUM_TERMS);

endpackage

// File: rtl/and_term_tally_if.sv
// rtl/and_term_tally_if.sv - sample-in / result-out handshake bundle for and_term_tally
//
// Purpose : groups the sample stream, the result beat stream and the busy flag.
// Signals : in_valid/in_ready/in_terms   sample stream (master -> slave)
//           out_valid/out_ready/out_idx/out_count/out_last   result beats (slave -> master)
//           busy   slave is draining results
// Modports: master = upstream/downstream environment, slave = the tally block.

interface and_term_tally_if
   import and_term_tally_pkg::*;
#(
   parameter int NUM_TERMS = DEF_NUM_TERMS,
   parameter int CNT_W     = DEF_CNT_W,
   parameter int IDX_W     = idx_width(NUM_TERMS)
);

   logic                 in_valid;
   logic                 in_ready;
   logic [NUM_TERMS-1:0] in_terms;
   logic                 out_valid;
   logic                 out_ready;
   logic [IDX_W-1:0]     out_idx;
   logic [CNT_W-1:0]     out_count;
   logic                 out_last;
   logic                 busy;

   modport master (
      output in_valid, in_terms, out_ready,
      input  in_ready, out_valid, out_idx, out_count, out_last, busy
   );

   modport slave (
      input  in_valid, in_terms, out_ready,
      output in_ready, out_valid, out_idx, out_count, out_last, busy
   );

endinterface

// File: rtl/and_term_tally_sat_counter.sv
// rtl/and_term_tally_sat_counter.sv - saturating up-counter with synchronous clear
//
// Purpose : one per-term tally; counts up by one on inc, sticks at all-ones,
//           clr has priority over inc.
// Ports   : clk, rst_n (async active-low), inc, clr, count[CNT_W-1:0].

module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/and_term_tally.sv
// rtl/and_term_tally.sv - per-term tally of AND-network outputs over a fixed sample window
//
// Purpose : accumulates, for each of NUM_TERMS conjunction terms, how many
//           accepted samples had that term true. After WINDOW accepted samples
//           the block stops accepting and emits one result beat per term
//           (index 0 first), then clears the tallies and re-opens the window.
// Ports   : clk             rising-edge clock
//           rst_n           asynchronous active-low reset
//           bus (slave)     in_valid/in_ready/in_terms sample stream,
//                           out_valid/out_ready/out_idx/out_count/out_last
//                           result beats, busy = draining.

module and_term_tally
   import and_term_tally_pkg::*;
#(
   parameter int NUM_TERMS = DEF_NUM_TERMS,
   parameter int CNT_W     = DEF_CNT_W,
   parameter int WINDOW    = DEF_WINDOW
) (
   input  logic            clk,
   input  logic            rst_n,
   and_term_tally_if.slave bus
);

   localparam int               IDX_W    = idx_width(NUM_TERMS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TERMS - 1);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

   state_t            state_q;
   state_t            state_d;
   logic [WIN_W-1:0]  win_q;
   logic [IDX_W-1:0]  idx_q;

   logic              in_ready;
   logic              out_valid;
   logic              accept;
   logic              beat;
   logic              clr;
   logic [CNT_W-1:0]  sel_count;
   logic [CNT_W-1:0]  cnt [NUM_TERMS];

   // Next state and handshake decode
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      beat      = 1'b0;
      clr       = 1'b0;
      case (state_q)
         ST_ACCUM: begin
            in_ready = 1'b1;
            accept   = bus.in_valid;
            if (accept && (win_q == WIN_LAST)) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            out_valid = 1'b1;
            beat      = bus.out_ready;
            // The final beat wipes the tallies so the next window starts clean.
            if (beat && (idx_q == LAST_IDX)) begin
               clr     = 1'b1;
               state_d = ST_ACCUM;
            end
         end
         default: begin
            state_d = ST_ACCUM;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_ACCUM;
      end else begin
         state_q <= state_d;
      end
   end

   // Window position and result index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q <= '0;
         idx_q <= '0;
      end else begin
         if (accept) begin
            win_q <= (win_q == WIN_LAST) ? '0 : win_q + WIN_W'(1);
         end
         if (beat) begin
            idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
         end
      end
   end

   // Per-term tallies
   for (genvar g = 0; g < NUM_TERMS; g++) begin : g_cnt
      sat_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .inc   (accept & bus.in_terms[g]),
         .clr   (clr),
         .count (cnt[g])
      );
   end

   // Result mux reads only registered state; an explicit compare loop keeps
   // out-of-range index codes (non power-of-two NUM_TERMS) well defined.
   always_comb begin
      sel_count = '0;
      for (int i = 0; i < NUM_TERMS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            sel_count = cnt[i];
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.busy      = out_valid;
   assign bus.out_idx   = idx_q;
   // Outputs are forced quiet outside DRAIN so the bus shows zeros while accumulating.
   assign bus.out_count = out_valid ? sel_count : '0;
   assign bus.out_last  = out_valid && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_and_term_tally.sv
// tb/tb_and_term_tally.sv - self-checking bench for and_term_tally

module tb_and_term_tally;

   localparam int NT = 11;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;
   int   exp_a [NT];
   int   exp_b [NT];

   and_term_tally_if #(.NUM_TERMS(NT), .CNT_W(8)) a_if ();
   and_term_tally_if #(.NUM_TERMS(NT), .CNT_W(4)) b_if ();

   and_term_tally #(.NUM_TERMS(NT), .CNT_W(8), .WINDOW(16)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (a_if.slave)
   );

   and_term_tally #(.NUM_TERMS(NT), .CNT_W(4), .WINDOW(20)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int v, input int m);
      return (v > m) ? m : v;
   endfunction

   // mode 0 all-ones, 1 alternating 555/2AA with 3-cycle gaps,
   // 2 random terms with random gaps, 3 only term 0
   task automatic feed_a(input int mode, input int max_gap);
      logic [NT-1:0] t;
      int g;
      for (int s = 0; s < 16; s++) begin
         g = (mode == 1) ? 3 : (mode == 2) ? int'($urandom_range(0, max_gap)) : 0;
         for (int k = 0; k < g; k++) begin
            a_if.in_valid = 1'b0;
            a_if.in_terms = NT'($urandom);
            check("a_gap_ready", 32'(a_if.in_ready), 1);
            @(negedge clk);
         end
         case (mode)
            0:       t = '1;
            1:       t = (s % 2 == 0) ? 11'h555 : 11'h2AA;
            2:       t = NT'($urandom);
            default: t = 11'h001;
         endcase
         check("a_open_ready", 32'(a_if.in_ready), 1);
         check("a_open_busy", 32'(a_if.busy), 0);
         a_if.in_valid = 1'b1;
         a_if.in_terms = t;
         for (int i = 0; i < NT; i++) exp_a[i] += int'(t[i]);
         @(negedge clk);
      end
      a_if.in_valid = 1'b0;
   endtask

   task automatic drain_a(input int stall_idx, input int stall_len, input bit rnd_ready,
                          input int rst_idx);
      int  k;
      int  stalled;
      int  guard;
      logic r;
      k = 0; stalled = 0; guard = 0;
      while (k < NT && guard < 400) begin
         check("a_out_valid", 32'(a_if.out_valid), 1);
         check("a_busy", 32'(a_if.busy), 1);
         check("a_in_ready_drain", 32'(a_if.in_ready), 0);
         check("a_out_idx", 32'(a_if.out_idx), k);
         check("a_out_count", 32'(a_if.out_count), sat(exp_a[k], 255));
         check("a_out_last", 32'(a_if.out_last), (k == NT - 1) ? 1 : 0);
         if (k == rst_idx) begin
            #2 rst_n = 1'b0;
            #1;
            check("a_rst_out_valid", 32'(a_if.out_valid), 0);
            check("a_rst_busy", 32'(a_if.busy), 0);
            check("a_rst_out_count", 32'(a_if.out_count), 0);
            check("a_rst_out_last", 32'(a_if.out_last), 0);
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            a_if.in_valid  = 1'b0;
            a_if.out_ready = 1'b1;
            #1;
            check("a_rst_in_ready", 32'(a_if.in_ready), 1);
            foreach (exp_a[i]) exp_a[i] = 0;
            @(negedge clk);
            return;
         end
         if (k == stall_idx && stalled < stall_len) begin
            r = 1'b0;
            stalled++;
         end else if (rnd_ready) begin
            r = 1'($urandom_range(0, 1));
         end else begin
            r = 1'b1;
         end
         a_if.out_ready = r;
         a_if.in_valid  = 1'($urandom_range(0, 1));
         a_if.in_terms  = NT'($urandom);
         @(negedge clk);
         guard++;
         if (r) k++;
      end
      check("a_drain_beats", k, NT);
      a_if.in_valid  = 1'b0;
      a_if.out_ready = 1'b1;
      check("a_after_in_ready", 32'(a_if.in_ready), 1);
      check("a_after_out_valid", 32'(a_if.out_valid), 0);
      check("a_after_busy", 32'(a_if.busy), 0);
      foreach (exp_a[i]) exp_a[i] = 0;
   endtask

   task automatic feed_b(input int mode);
      logic [NT-1:0] t;
      for (int s = 0; s < 20; s++) begin
         t = (mode == 0) ? '1 : NT'($urandom);
         check("b_open_ready", 32'(b_if.in_ready), 1);
         check("b_open_busy", 32'(b_if.busy), 0);
         b_if.in_valid = 1'b1;
         b_if.in_terms = t;
         for (int i = 0; i < NT; i++) exp_b[i] += int'(t[i]);
         @(negedge clk);
      end
      b_if.in_valid = 1'b0;
   endtask

   task automatic drain_b();
      for (int k = 0; k < NT; k++) begin
         check("b_out_valid", 32'(b_if.out_valid), 1);
         check("b_out_idx", 32'(b_if.out_idx), k);
         check("b_out_count", 32'(b_if.out_count), sat(exp_b[k], 15));
         check("b_out_last", 32'(b_if.out_last), (k == NT - 1) ? 1 : 0);
         b_if.out_ready = 1'b1;
         @(negedge clk);
      end
      check("b_after_in_ready", 32'(b_if.in_ready), 1);
      check("b_after_out_valid", 32'(b_if.out_valid), 0);
      foreach (exp_b[i]) exp_b[i] = 0;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      foreach (exp_a[i]) exp_a[i] = 0;
      foreach (exp_b[i]) exp_b[i] = 0;
      rst_n          = 1'b0;
      a_if.in_valid  = 1'b0;
      a_if.in_terms  = '0;
      a_if.out_ready = 1'b1;
      b_if.in_valid  = 1'b0;
      b_if.in_terms  = '0;
      b_if.out_ready = 1'b1;

      @(negedge clk);
      @(negedge clk);
      check("rst_a_out_valid", 32'(a_if.out_valid), 0);
      check("rst_a_out_count", 32'(a_if.out_count), 0);
      check("rst_a_out_last", 32'(a_if.out_last), 0);
      check("rst_a_busy", 32'(a_if.busy), 0);
      check("rst_b_out_valid", 32'(b_if.out_valid), 0);
      rst_n = 1'b1;
      #1;
      check("rel_a_in_ready", 32'(a_if.in_ready), 1);
      check("rel_b_in_ready", 32'(b_if.in_ready), 1);
      @(negedge clk);

      feed_a(0, 0); drain_a(-1, 0, 1'b0, -1);
      feed_a(1, 3); drain_a(-1, 0, 1'b0, -1);
      feed_a(2, 2); drain_a(3, 5, 1'b0, -1);
      feed_a(2, 2); drain_a(-1, 0, 1'b1, -1);
      feed_a(2, 1); drain_a(-1, 0, 1'b0, 6);
      feed_a(3, 0); drain_a(-1, 0, 1'b0, -1);

      feed_b(0); drain_b();
      feed_b(1); drain_b();

      for (int r = 0; r < 4; r++) begin
         feed_a(2, 3);
         drain_a(int'($urandom_range(0, NT - 1)), int'($urandom_range(1, 4)), 1'b1, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
